rr_sel_arbiter8: RTL and testbench
==================================

// Module: rr_sel_arbiter8
// PURPOSE
// - Round-robin arbiter over 8 request lines. Produces a registered 3-bit binary grant index with valid/ready handshake.
// - Sits directly upstream of the 3-to-8 decoder. grant_idx drives the decoder input; the decoder's one-hot output is the per-channel enable.
// - Guarantees a stable index while a grant is pending and starvation-free rotation across requesters.
// PARAMETERS
// - RESET_PTR  default 3'd7  last-granted pointer after reset; 7 gives req[0] first priority
// - BACK2BACK  default 1     1: a new grant may be issued the same cycle the current one is accepted; 0: one IDLE bubble between grants
// PORTS
// - clk        in   1  rising-edge clock
// - rst_n      in   1  asynchronous active-low reset
// - req        in   8  request lines, level-sensitive, bit i = requester i
// - grant_rdy  in   1  downstream accepts current grant when high with grant_vld
// - grant_vld  out  1  grant_idx holds a valid grant
// - grant_idx  out  3  binary index of granted requester, to decoder input
// - last_ptr   out  3  index of most recently accepted grant (debug/status)
// - lock       in   1  present only with SEL_ARB_LOCK_EN; see CONFIGURATION
// BEHAVIOUR
// - One clock (clk) and one reset (rst_n); rst_n is asynchronous, active-low. Assert is immediate; release is synchronous to clk.
// - Reset values: grant_vld=0, grant_idx=3'd0, last_ptr=RESET_PTR, FSM=IDLE.
// - FSM states:
//   - IDLE: grant_vld=0. If req!=0, pick the first set bit scanning (last_ptr+1) .. (last_ptr+8), mod 8, with wrap 7->0.
//     Register it into grant_idx. Next cycle: GRANT, grant_vld=1. Latency from req to grant_vld is 1 cycle. If req==0, stay in IDLE.
//   - GRANT: grant_vld=1 and grant_idx stable. Neither changes until grant_rdy=1.
//     - Grants are never retracted. If the granted req bit drops while pending, the grant stays until accepted.
//     - On grant_vld & grant_rdy: last_ptr<=grant_idx.
//       - If BACK2BACK=1 and any req other than the accepted one is set: compute the next grant from the accepted index and stay in GRANT with the new grant_idx.
//       - If BACK2BACK=1 and only the accepted req is set: re-grant it.
//       - Otherwise go to IDLE.
//     - If BACK2BACK=0: always return to IDLE after acceptance.
// - Arbitration arithmetic: pointer and index are 3-bit modulo-8. The search is a fixed 8-position rotate plus priority-encode.
// - Fairness: with all 8 reqs held, accepted indices cycle RESET_PTR+1, +2, ... mod 8, each exactly once per 8 acceptances.
// - Reset mid-GRANT: grant_vld drops immediately and asynchronously, and the pending grant is discarded.
// - grant_rdy while grant_vld=0 is ignored.
// - X on req while IDLE is not permitted. The bench checks req is known whenever FSM=IDLE.
// CONFIGURATION
// - SEL_ARB_LOCK_EN defined: adds input lock.
//   - On acceptance with lock=1, last_ptr is still updated but the next grant is forced to the same index if its req bit is set, bypassing rotation.
//   - If its req bit is clear, normal rotation applies. lock is ignored in IDLE.
// - SEL_ARB_LOCK_EN undefined: no lock port; rotation always applies.
// TESTING
// - Reset: rst_n=0 with req=8'hFF -> grant_vld=0, grant_idx=0, last_ptr=7; release -> 1 cycle later grant_vld=1, grant_idx=0.
// - Rotation: req=8'hFF, grant_rdy=1 held, BACK2BACK=1 -> grant_idx sequence 0,1,2,...,7,0 on consecutive cycles.
// - Sparse wrap: last_ptr=6, req=8'b0000_0101 -> grant_idx=0 next, then 2, then 0.
// - Backpressure: grant issued idx=3, grant_rdy=0 for 5 cycles while req changes -> grant_vld=1, grant_idx=3 stable; accepted on rdy.
// - Reset mid-grant: async rst_n low mid-cycle in GRANT -> grant_vld=0 before the next clk edge; after release the pointer restarts from RESET_PTR.
// - Lock (SEL_ARB_LOCK_EN): req=8'h30, lock=1, rdy=1 -> idx 4 repeated; lock=0 -> next idx 5.

Source files
------------

// File: rtl/rr_sel_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_sel_arbiter8
// Purpose  : 8-way round-robin arbiter with a registered binary grant index and
//            valid/ready handoff; optional grant lock via SEL_ARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module rr_sel_arbiter8 #(
    parameter logic [2:0] RESET_PTR = 3'd7,
    parameter bit         BACK2BACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_rdy,
`ifdef SEL_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       grant_vld,
    output logic [2:0] grant_idx,
    output logic [2:0] last_ptr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic       grant_vld_q;
    logic [2:0] grant_idx_q;
    logic [2:0] last_ptr_q;

    logic [2:0] idle_pick_d;
    logic [2:0] acc_pick_d;
    logic [2:0] next_idx_d;

    // Rotate so that position ptr+1 lands at bit 0, then take the lowest set bit.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  start;
        logic [2:0]  off;
        dbl   = {r, r};
        start = ptr + 3'd1;
        rot   = dbl[start +: 8];
        off   = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (rot[j]) begin
                off = 3'(j);
            end
        end
        return start + off;
    endfunction

    always_comb begin
        idle_pick_d = rr_pick(req, last_ptr_q);
        acc_pick_d  = rr_pick(req, grant_idx_q);
        next_idx_d  = acc_pick_d;
`ifdef SEL_ARB_LOCK_EN
        if (lock && req[grant_idx_q]) begin
            next_idx_d = grant_idx_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_vld_q <= 1'b0;
            grant_idx_q <= 3'd0;
            last_ptr_q  <= RESET_PTR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_idx_q <= idle_pick_d;
                        grant_vld_q <= 1'b1;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Index is frozen until accepted, even if its request drops.
                    if (grant_rdy) begin
                        last_ptr_q <= grant_idx_q;
                        if (BACK2BACK && (|req)) begin
                            grant_idx_q <= next_idx_d;
                        end else begin
                            grant_vld_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    grant_vld_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_vld = grant_vld_q;
    assign grant_idx = grant_idx_q;
    assign last_ptr  = last_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rr_sel_arbiter8
// Purpose  : Scoreboard bench for rr_sel_arbiter8 against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rr_sel_arbiter8;

    localparam logic [2:0] RP  = 3'd7;
    localparam bit         B2B = 1'b1;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] req       = 8'hFF;
    logic       grant_rdy = 1'b0;
`ifdef SEL_ARB_LOCK_EN
    logic       lock      = 1'b0;
`endif
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [2:0] last_ptr;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_q[$];
    logic       m_pend;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;

    always #5 clk = ~clk;

    rr_sel_arbiter8 #(.RESET_PTR(RP), .BACK2BACK(B2B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_rdy (grant_rdy),
`ifdef SEL_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .last_ptr  (last_ptr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester found walking upward from the pointer, wrapping mod 8.
    function automatic logic [2:0] ref_pick(input logic [7:0] r, input logic [2:0] p);
        int i;
        for (int k = 1; k <= 8; k++) begin
            i = (int'(p) + k) % 8;
            if (r[i]) return 3'(i);
        end
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0;
            m_ptr  = RP;
            m_idx  = 3'd0;
            exp_q.delete();
        end else if (!m_pend) begin
            if (req != 8'h00) begin
                m_idx  = ref_pick(req, m_ptr);
                m_pend = 1'b1;
                exp_q.push_back(m_idx);
            end
        end else if (grant_rdy) begin
            m_ptr = m_idx;
            if (B2B && req != 8'h00) begin
`ifdef SEL_ARB_LOCK_EN
                if (!(lock && req[m_idx])) m_idx = ref_pick(req, m_ptr);
`else
                m_idx = ref_pick(req, m_ptr);
`endif
                exp_q.push_back(m_idx);
            end else begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_vld", {7'd0, grant_vld}, 8'd0);
            check("rst_idx", {5'd0, grant_idx}, 8'd0);
            check("rst_ptr", {5'd0, last_ptr}, {5'd0, RP});
        end else begin
            check("vld", {7'd0, grant_vld}, {7'd0, exp_q.size() != 0});
            if (grant_vld && exp_q.size() != 0) begin
                check("idx", {5'd0, grant_idx}, {5'd0, exp_q[0]});
                if (grant_rdy) void'(exp_q.pop_front());
            end
            check("last_ptr", {5'd0, last_ptr}, {5'd0, m_ptr});
            if (!grant_vld) check("req_known", {7'd0, $isunknown(req)}, 8'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("first_vld", {7'd0, grant_vld}, 8'd1);
        check("first_idx", {5'd0, grant_idx}, 8'd0);

        grant_rdy = 1'b1;
        repeat (10) tick();

        // Sparse wrap from pointer 6 with requesters 0 and 2.
        grant_rdy = 1'b0;
        req = 8'h40;
        pulse_reset();
        repeat (2) tick();
        req = 8'h05;
        grant_rdy = 1'b1;
        repeat (5) tick();

        // Backpressure on index 3.
        grant_rdy = 1'b0;
        req = 8'h08;
        pulse_reset();
        repeat (2) tick();
        for (int c = 0; c < 5; c++) begin
            req = 8'($urandom);
            tick();
            check("hold_vld", {7'd0, grant_vld}, 8'd1);
            check("hold_idx", {5'd0, grant_idx}, 8'd3);
        end
        grant_rdy = 1'b1;
        tick();
        check("bp_ptr", {5'd0, last_ptr}, 8'd3);

        // Asynchronous reset while a grant is pending.
        grant_rdy = 1'b0;
        req = 8'hFF;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("async_vld", {7'd0, grant_vld}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_idx", {5'd0, grant_idx}, 8'd0);

`ifdef SEL_ARB_LOCK_EN
        req = 8'h30;
        pulse_reset();
        lock = 1'b1;
        grant_rdy = 1'b1;
        repeat (4) tick();
        lock = 1'b0;
        repeat (3) tick();
`endif

        for (int c = 0; c < 400; c++) begin
            req       = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            grant_rdy = 1'($urandom % 2);
`ifdef SEL_ARB_LOCK_EN
            lock      = 1'($urandom % 2);
`endif
            if ($urandom % 64 == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        req = 8'h00;
        grant_rdy = 1'b1;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
